ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
- Receives PS/2 keyboard frames on the board's ps2_clk/ps2_data pins and validates each 11-bit frame.
- Stores accepted scan codes in a small show-ahead FIFO.
- The downstream consumer (scan-code decode, then bcd7seg display) pops codes with a one-cycle read strobe.
- Sits directly between the top-level PS/2 pins and the display/decode logic.

Parameters:
- FIFO_DEPTH, 8, number of scan-code entries; must be a power of 2, minimum 2.
- TIMEOUT, 5000, clk cycles without a ps2_clk falling edge mid-frame before the bit counter resynchronises.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data, asynchronous to clk.
- rd_en  input  1  pop strobe from consumer; honoured only while ready=1.
- data  output  8  scan code at FIFO head, show-ahead; valid while ready=1.
- ready  output  1  FIFO non-empty.
- overflow  output  1  sticky: a valid frame arrived while the FIFO was full.
- frame_err  output  1  one-cycle pulse on a rejected frame.
- fifo_count  output  log2(FIFO_DEPTH)+1  number of stored entries.

Behaviour:
- Reset is synchronous on a clk edge with rst=1. It clears:
  - synchronisers to 1s;
  - bit counter, shift register, timeout counter, FIFO pointers and count;
  - ready=0, overflow=0, frame_err=0, fifo_count=0.
  - data reads entry 0; its value is don't-care while ready=0.
- Reset mid-frame discards the partial frame. Reset with a full FIFO empties it.
- Synchronisation:
  - ps2_clk passes through a 3-flop shift register. A falling edge is detected when stage2=1 and stage1=0, giving a 1-cycle pulse.
  - ps2_data passes through 2 flops, aligned so it is sampled on the same cycle as the falling-edge pulse.
- Frame capture:
  - On each falling-edge pulse, shift the data bit into an 11-bit register, LSB first, and increment bit_cnt.
  - Frame layout: bit0 = start (must be 0), bits1-8 = data LSB-first, bit9 = odd parity, bit10 = stop (must be 1).
  - When the 11th bit is captured (bit_cnt was 10), evaluate the frame on that same pulse and return bit_cnt to 0.
- Frame check:
  - Valid iff start==0, stop==1, and XOR of bits1-9 == 1.
  - Invalid: frame_err=1 for exactly the next cycle; nothing is written to the FIFO.
- Write:
  - A valid frame writes data bits 8:1 at wr_ptr on the clk edge following the 11th pulse.
  - ready and fifo_count update on that same edge.
  - Latency from the 11th synchronised edge pulse to ready=1: 1 clk.
- Full:
  - A valid frame while count==FIFO_DEPTH and no pop in the same cycle is dropped and sets overflow=1.
  - overflow stays set until rst. The FIFO contents are untouched.
- Read:
  - rd_en=1 with ready=1 advances rd_ptr and decrements the count on that edge.
  - rd_en with ready=0 is ignored: no pointer movement, no error.
- Simultaneous pop and push:
  - When full: the pop happens first, the push succeeds, fifo_count stays at FIFO_DEPTH, overflow is not set.
  - When non-empty: the count is unchanged and both pointers advance.
  - When empty: the push occurs, the rd_en is ignored, and the count becomes 1.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Timeout:
  - While bit_cnt != 0, count clk cycles since the last falling-edge pulse.
  - Reaching TIMEOUT forces bit_cnt=0 and clears the timeout counter. No frame_err is raised.
  - Each pulse restarts the count; the counter is held at 0 while bit_cnt == 0.
- Multi-byte codes (E0 prefix, F0 break) are not interpreted; each byte is stored as received.

Test Plan:
- Reset, then send one frame of 0x1C with bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0, stop 1) and ps2 half-period 20 clk. Required: after the 11th edge, ready=1, data=0x1C, fifo_count=1 within 5 clk; rd_en pulse gives ready=0, fifo_count=0.
- Send 0xF0 then 0x1C. Required: data=0xF0 first; after a pop, data=0x1C; after a second pop, ready=0; frame_err never set.
- Send 0x1C with the parity bit flipped to 1. Required: frame_err high for exactly 1 clk; ready stays 0. Repeat with stop=0: same response.
- FIFO_DEPTH=8, send 9 valid frames 0x01..0x09 with no reads. Required: fifo_count=8, overflow=1, popping yields 0x01..0x08 in order, 0x09 absent. A 10th frame sent while full with rd_en asserted on its write cycle: accepted, overflow unchanged, fifo_count stays 8.
- Send 5 bits, then idle more than TIMEOUT clk, then a full valid 0x2A frame. Required: data=0x2A, no frame_err.
- Assert rst mid-frame (bit 6) with 3 entries queued. Required: next cycle ready=0, fifo_count=0, overflow=0; a following 0x1C frame is received correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx_if.sv
// Consumer-side bus of the PS/2 keyboard receiver: show-ahead FIFO head, status and pop strobe.
// master = receiver (drives data/status), slave = consumer (drives rd_en).
interface ps2_keyboard_rx_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic [7:0]    data;
    logic          ready;
    logic          overflow;
    logic          frame_err;
    logic [CW-1:0] fifo_count;

    modport master (
        input  rd_en,
        output data, ready, overflow, frame_err, fifo_count
    );

    modport slave (
        output rd_en,
        input  data, ready, overflow, frame_err, fifo_count
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the raw pins, validates 11-bit frames and
// queues accepted scan codes in a show-ahead FIFO popped by a one-cycle strobe.
module ps2_keyboard_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_keyboard_rx_if.master bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW = 4;

    logic [2:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic [10:0]   shift_q, shift_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          fall_c;
    logic [10:0]   frame_c;
    logic          last_c;
    logic          valid_c;
    logic          pop_c;
    logic          full_c;
    logic          push_c;

    // Index 0 is the newest synchroniser stage; data stage 1 lines up with the fall pulse.
    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};

        fall_c  = clk_sync_q[2] & ~clk_sync_q[1];
        frame_c = {data_sync_q[1], shift_q[10:1]};
        last_c  = fall_c && (bit_cnt_q == BW'(10));
        valid_c = last_c && !frame_c[0] && frame_c[10] && (^frame_c[9:1]);
        pop_c   = bus.rd_en && ready_q;
        full_c  = (count_q == CW'(FIFO_DEPTH));
        push_c  = valid_c && (!full_c || pop_c);

        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        overflow_d  = overflow_q;
        frame_err_d = last_c && !valid_c;

        if (fall_c) begin
            shift_d   = frame_c;
            to_cnt_d  = '0;
            bit_cnt_d = last_c ? '0 : bit_cnt_q + BW'(1);
        end else if (bit_cnt_q != '0) begin
            // A stalled frame is abandoned silently so the next start bit realigns.
            if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                bit_cnt_d = '0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end

        if (valid_c && full_c && !pop_c) begin
            overflow_d = 1'b1;
        end

        wr_ptr_d = wr_ptr_q + PW'(push_c);
        rd_ptr_d = rd_ptr_q + PW'(pop_c);
        count_d  = count_q + CW'(push_c) - CW'(pop_c);
        ready_d  = (count_d != '0);

        // Registered show-ahead head: bypass the incoming byte when it lands at the new head.
        data_d = (push_c && (wr_ptr_q == rd_ptr_d)) ? frame_c[8:1] : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            data_q      <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            data_q      <= data_d;
        end
    end

    // Storage array needs no reset; stale entries are never visible while empty.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem_q[wr_ptr_q] <= frame_c[8:1];
        end
    end

    assign bus.data       = data_q;
    assign bus.ready      = ready_q;
    assign bus.overflow   = overflow_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx with a scoreboard queue of expected scan codes.
module tb_ps2_keyboard_rx;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 5000;
    localparam int          HALF    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_keyboard_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int lat;
    int err_cycles = 0;
    int err_edges = 0;
    logic err_prev = 1'b0;
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) err_cycles++;
        if (bus.frame_err === 1'b1 && err_prev !== 1'b1) err_edges++;
        err_prev = bus.frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mkf(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // Bits change while ps2_clk is high; the receiver samples on the falling edge.
    task automatic send_raw(input logic [10:0] f, input int nbits, input bit pop_on_write);
        logic [7:0] cnt0;
        logic [7:0] e;
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            cnt0 = 8'(bus.fifo_count);
            for (int c = 1; c <= HALF; c++) begin
                @(negedge clk);
                if (i == nbits - 1) begin
                    if (lat < 0 && 8'(bus.fifo_count) != cnt0) lat = c;
                    if (pop_on_write && c == 2) begin
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                        chk("pop_on_write_data", 32'(bus.data), 32'(e));
                        bus.rd_en = 1'b1;
                    end
                    if (pop_on_write && c == 3) bus.rd_en = 1'b0;
                end
            end
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_valid(input logic [7:0] b);
        exp_q.push_back(b);
        send_raw(mkf(b, 1'b0, 1'b0), 11, 1'b0);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_data"}, 32'(bus.data), 32'(e));
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int e0;
        int c0;
        bus.rd_en = 1'b0;
        do_reset();
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);

        // Single frame 0x1C: latency, head value, count, then pop to empty
        chk("frame_1c_bits", 32'(mkf(8'h1C, 1'b0, 1'b0)), 32'b100_0011_1000);
        send_valid(8'h1C);
        chk("lat_le5", 32'(lat > 0 && lat <= 5), 32'd1);
        chk("one_count", 32'(bus.fifo_count), 32'd1);
        pop_check("one");
        chk("one_empty_ready", 32'(bus.ready), 32'd0);
        chk("one_empty_count", 32'(bus.fifo_count), 32'd0);

        // Break sequence F0 1C, in order, with no frame errors
        e0 = err_cycles;
        send_valid(8'hF0);
        send_valid(8'h1C);
        chk("brk_count", 32'(bus.fifo_count), 32'd2);
        pop_check("brk0");
        pop_check("brk1");
        chk("brk_empty", 32'(bus.ready), 32'd0);
        chk("brk_no_err", 32'(err_cycles - e0), 32'd0);

        // Bad parity, then bad stop: one-cycle frame_err, nothing stored
        e0 = err_cycles; c0 = err_edges;
        send_raw(mkf(8'h1C, 1'b1, 1'b0), 11, 1'b0);
        chk("par_err_cycles", 32'(err_cycles - e0), 32'd1);
        chk("par_err_edges", 32'(err_edges - c0), 32'd1);
        chk("par_ready", 32'(bus.ready), 32'd0);
        e0 = err_cycles; c0 = err_edges;
        send_raw(mkf(8'h1C, 1'b0, 1'b1), 11, 1'b0);
        chk("stop_err_cycles", 32'(err_cycles - e0), 32'd1);
        chk("stop_err_edges", 32'(err_edges - c0), 32'd1);
        chk("stop_ready", 32'(bus.ready), 32'd0);

        // Fill past depth: ninth frame dropped and flagged
        for (int i = 1; i <= 8; i++) send_valid(8'(i));
        chk("full_no_ovf", 32'(bus.overflow), 32'd0);
        send_raw(mkf(8'h09, 1'b0, 1'b0), 11, 1'b0);
        chk("full_count", 32'(bus.fifo_count), 32'd8);
        chk("full_ovf", 32'(bus.overflow), 32'd1);
        // Tenth frame with a pop on its write cycle is accepted
        exp_q.push_back(8'h0A);
        send_raw(mkf(8'h0A, 1'b0, 1'b0), 11, 1'b1);
        chk("popwr_count", 32'(bus.fifo_count), 32'd8);
        chk("popwr_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 8; i++) pop_check("drain");
        chk("drain_empty", 32'(bus.ready), 32'd0);
        chk("drain_ovf_sticky", 32'(bus.overflow), 32'd1);

        // rd_en while empty is ignored
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
        chk("empty_pop_count", 32'(bus.fifo_count), 32'd0);

        // Stalled partial frame resynchronises after the timeout
        e0 = err_cycles;
        send_raw(mkf(8'h55, 1'b0, 1'b0), 5, 1'b0);
        repeat (TIMEOUT + 100) @(negedge clk);
        send_valid(8'h2A);
        pop_check("timeout");
        chk("timeout_no_err", 32'(err_cycles - e0), 32'd0);

        // Reset mid-frame with entries queued
        send_valid(8'h11);
        send_valid(8'h22);
        send_valid(8'h33);
        chk("pre_rst_count", 32'(bus.fifo_count), 32'd3);
        send_raw(mkf(8'h44, 1'b0, 1'b0), 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_ready", 32'(bus.ready), 32'd0);
        chk("midrst_count", 32'(bus.fifo_count), 32'd0);
        chk("midrst_ovf", 32'(bus.overflow), 32'd0);
        repeat (5) @(negedge clk);
        send_valid(8'h1C);
        pop_check("post_rst");
        chk("post_rst_empty", 32'(bus.ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
